// File: rtl/uart_tx_serializer_if.sv
// Request/line bundle between a UART TX client and uart_tx_serializer.
// The client (master) drives the byte, framing options and bit period;
// the serializer (slave) drives the serial line and its busy flag.
interface uart_tx_serializer_if #(
  parameter int DATA_WD     = 8,
  parameter int prescale_wd = 6
);
  logic [DATA_WD-1:0]     P_DATA;
  logic                   DATA_VALID;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic [prescale_wd-1:0] prescale;
  logic                   TX_OUT;
  logic                   busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_WD data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts the latched prescale period,
// so TX bit timing lines up with the RX oversampling windows.
// TX_OUT and busy are registered from the next-state decode, so the
// start bit appears on the cycle right after the accepting edge.
module uart_tx_serializer #(
  parameter int DATA_WD     = 8,
  parameter int prescale_wd = 6
) (
  input logic                   CLK,
  input logic                   RST,
  uart_tx_serializer_if.slave   bus
);

  localparam int BIT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [prescale_wd-1:0] edge_cnt, edge_cnt_next;
  logic [prescale_wd-1:0] period;
  logic [BIT_WD-1:0]      bit_cnt, bit_cnt_next;
  logic [DATA_WD-1:0]     data_reg;
  logic                   par_en_reg;
  logic                   par_bit;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;
  logic                   accept;
  logic                   bit_end;

  assign accept  = (state == IDLE) && bus.DATA_VALID;
  assign bit_end = (edge_cnt == (period - prescale_wd'(1)));

  assign bus.TX_OUT = tx_reg;
  assign bus.busy   = busy_reg;

  // State, counters and registered line outputs; reset forces the idle line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_cnt_next;
      bit_cnt  <= bit_cnt_next;
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
    end
  end

  // Frame snapshot taken only at acceptance so mid-frame input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg   <= '0;
      par_en_reg <= 1'b0;
      par_bit    <= 1'b0;
      period     <= '0;
    end else if (accept) begin
      data_reg   <= bus.P_DATA;
      par_en_reg <= bus.PAR_EN;
      par_bit    <= (^bus.P_DATA) ^ bus.PAR_TYP;
      period     <= (bus.prescale == '0) ? prescale_wd'(1) : bus.prescale;
    end
  end

  // Next-state logic: advance through the frame one bit period at a time.
  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    bit_cnt_next  = bit_cnt;
    case (state)
      IDLE: begin
        if (bus.DATA_VALID) begin
          state_next    = START;
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (bit_end) begin
          edge_cnt_next = '0;
          case (state)
            START: begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end
            DATA: begin
              if (bit_cnt == BIT_WD'(DATA_WD - 1)) begin
                state_next = par_en_reg ? PARITY : STOP;
              end else begin
                bit_cnt_next = bit_cnt + BIT_WD'(1);
              end
            end
            PARITY:  state_next = STOP;
            default: state_next = IDLE;
          endcase
        end else begin
          edge_cnt_next = edge_cnt + prescale_wd'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered line has no lag.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = 1'b1;
    case (state_next)
      IDLE:    busy_next = 1'b0;
      START:   tx_next   = 1'b0;
      DATA:    tx_next   = data_reg[bit_cnt_next];
      PARITY:  tx_next   = par_bit;
      STOP:    tx_next   = 1'b1;
      default: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: every frame is checked cycle by
// cycle against a hand-written bit string, followed by the idle cycle.
module tb_uart_tx_serializer;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_serializer_if #(.DATA_WD(8), .prescale_wd(6)) bus ();

  uart_tx_serializer #(.DATA_WD(8), .prescale_wd(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is accepted on the next rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [5:0] p,
                               input logic par_en, input logic par_typ,
                               input bit hold);
    bus.P_DATA     = data;
    bus.prescale   = p;
    bus.PAR_EN     = par_en;
    bus.PAR_TYP    = par_typ;
    bus.DATA_VALID = 1'b1;
    @(posedge CLK);
    if (!hold) begin
      #1 bus.DATA_VALID = 1'b0;
    end
  endtask

  // seq lists line levels left to right; limit>0 stops early (no idle check);
  // disturbAt>0 pulses a foreign request and rewrites inputs at that cycle.
  task automatic checkFrame(input string seq, input int p, input string tag,
                            input int limit, input int disturbAt);
    int n = 0;
    for (int b = 0; b < seq.len(); b++) begin
      for (int c = 0; c < p; c++) begin
        if (limit != 0 && n >= limit) return;
        @(negedge CLK);
        n++;
        checkOutput($sformatf("%s b%0d c%0d tx", tag, b, c), bus.TX_OUT, seq[b] == 8'h31);
        checkOutput($sformatf("%s b%0d c%0d busy", tag, b, c), bus.busy, 1'b1);
        if (disturbAt != 0 && n == disturbAt) begin
          bus.DATA_VALID = 1'b1;
          bus.P_DATA     = 8'h3C;
          bus.prescale   = 6'd7;
          bus.PAR_EN     = 1'b0;
          bus.PAR_TYP    = 1'b0;
        end else if (disturbAt != 0 && n == disturbAt + 1) begin
          bus.DATA_VALID = 1'b0;
        end
      end
    end
    @(negedge CLK);
    checkOutput($sformatf("%s idle tx", tag), bus.TX_OUT, 1'b1);
    checkOutput($sformatf("%s idle busy", tag), bus.busy, 1'b0);
  endtask

  initial begin
    RST            = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.prescale   = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset tx", bus.TX_OUT, 1'b1);
    checkOutput("reset busy", bus.busy, 1'b0);
    RST = 1'b0;

    $display("[TB] even parity, P=8, 0xA5");
    applyStimulus(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0);
    checkFrame("01010010101", 8, "even", 0, 0);

    $display("[TB] no parity, P=4, 0xFF");
    applyStimulus(8'hFF, 6'd4, 1'b0, 1'b0, 1'b0);
    checkFrame("0111111111", 4, "nopar", 0, 0);

    $display("[TB] odd parity, P=1 and prescale=0, 0x03");
    applyStimulus(8'h03, 6'd1, 1'b1, 1'b1, 1'b0);
    checkFrame("01100000011", 1, "odd_p1", 0, 0);
    applyStimulus(8'h03, 6'd0, 1'b1, 1'b1, 1'b0);
    checkFrame("01100000011", 1, "odd_p0", 0, 0);

    $display("[TB] input isolation, 0x96 odd parity P=3, mid-frame disturbance");
    applyStimulus(8'h96, 6'd3, 1'b1, 1'b1, 1'b0);
    checkFrame("00110100111", 3, "iso", 0, 5);
    applyStimulus(8'h3C, 6'd7, 1'b0, 1'b0, 1'b0);
    checkFrame("0001111001", 7, "after_iso", 0, 0);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'h0F, 6'd2, 1'b0, 1'b0, 1'b0);
    checkFrame("0111100001", 2, "pre_rst", 9, 0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst tx", bus.TX_OUT, 1'b1);
    checkOutput("midrst busy", bus.busy, 1'b0);
    RST = 1'b0;
    applyStimulus(8'h55, 6'd2, 1'b1, 1'b0, 1'b0);
    checkFrame("01010101001", 2, "post_rst", 0, 0);

    $display("[TB] back-to-back, DATA_VALID held, P=2, 0x81");
    applyStimulus(8'h81, 6'd2, 1'b0, 1'b0, 1'b1);
    checkFrame("0100000011", 2, "b2b0", 0, 0);
    checkFrame("0100000011", 2, "b2b1", 0, 0);
    checkFrame("0100000011", 2, "b2b2", 0, 0);
    bus.DATA_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("b2b end tx", bus.TX_OUT, 1'b1);
    checkOutput("b2b end busy", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter that serializes one parallel byte per request into a standard asynchronous frame: start bit, DATA_WD data bits LSB first, optional parity bit, one stop bit. Each bit is held for `prescale` clock cycles. The block sits in the UART TX path opposite the RX oversampling counters and shares the same `prescale` ratio, so TX bit periods match RX sampling windows. It owns its bit-period counter, bit counter, parity generator and frame FSM; the line idles high.

## Interface
- `DATA_WD`, default 8: data bits per frame.
- `prescale_wd`, default 6: width of the `prescale` input.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `P_DATA`  in  DATA_WD  parallel byte to send; sampled only on acceptance.
- `DATA_VALID`  in  1  request to send; accepted only in a cycle where `busy`=0.
- `PAR_EN`  in  1  1 = append parity bit; sampled on acceptance.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on acceptance.
- `prescale`  in  prescale_wd  clock cycles per bit; sampled on acceptance.
- `TX_OUT`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `busy`=0. `DATA_VALID`=1 accepts the request. Acceptance registers `P_DATA`, `PAR_EN`, `PAR_TYP` and the bit period P, then enters START. The computed parity bit is registered at the same time.
- Bit period: P = `prescale`. A `prescale` value of 0 is treated as P=1.
- The edge counter runs from 0 to P-1 in each bit. On P-1 it wraps to 0 and the bit ends.
- End of START goes to DATA with bit_count=0.
- DATA drives data bit[bit_count]. At the end of a bit, bit_count increments. After bit DATA_WD-1 the FSM goes to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY bit = XOR of the latched data, XORed with PAR_TYP.
- End of STOP returns to IDLE.
- `DATA_VALID` while `busy`=1 is ignored and not queued.
- Changes to `P_DATA`, `PAR_*` or `prescale` mid-frame have no effect on the current frame.
- Reset value of both outputs is the IDLE value. `RST`=1 at any point, including mid-frame, forces on the next edge: IDLE, `TX_OUT`=1, `busy`=0, and counters and data registers cleared.
- `RST` has priority over `DATA_VALID`.

## Timing
- Acceptance edge t. From t+1: `TX_OUT`=0 (start bit) and `busy`=1.
- Each bit occupies exactly P cycles.
- Frame length F = (2 + DATA_WD + PAR_EN) × P cycles. `busy`=1 for cycles t+1 … t+F. At t+F+1: `busy`=0 and `TX_OUT`=1.
- Earliest next acceptance is edge t+F+1, which gives a start bit at t+F+2. The guaranteed idle-high gap is at least 1 cycle beyond the stop bit.
- No combinational path from any input to `TX_OUT` or `busy`.

## Test plan
- Even parity: P=8, `P_DATA`=0xA5, PAR_EN=1, PAR_TYP=0 → `TX_OUT` bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles. `busy` high for exactly 88 cycles.
- No parity: P=4, `P_DATA`=0xFF, PAR_EN=0 → sequence 0, eight 1s, 1. `busy` high for exactly 40 cycles. No parity slot.
- Odd parity, minimum period: P=1, `P_DATA`=0x03, PAR_EN=1, PAR_TYP=1 → sequence 0,1,1,0,0,0,0,0,0,1,1, one cycle per bit. `prescale`=0 gives an identical result.
- Input isolation: `DATA_VALID` pulsed with 0x3C while `busy`=1, and `P_DATA`/`prescale` changed mid-frame → current frame unchanged, second request dropped. A request 1 cycle after `busy` falls starts a new frame on the next edge.
- Reset mid-frame: `RST`=1 during DATA bit 3 → next edge `TX_OUT`=1, `busy`=0. After release, a new request with 0x55 transmits a complete correct frame.
- Back-to-back: `DATA_VALID` held high continuously with P=2 → frames repeat with exactly one idle-high cycle between each stop bit and the next start bit.
